// File: rtl/aes_pkg.sv
// aes_pkg: shared AES GF(2^8) constants, types and the xtime helper
package aes_pkg;
  localparam logic [7:0] AES_POLY_LO = 8'h1b;
  localparam logic [7:0] INV_MC_09 = 8'h09;
  localparam logic [7:0] INV_MC_0B = 8'h0b;
  localparam logic [7:0] INV_MC_0D = 8'h0d;
  localparam logic [7:0] INV_MC_0E = 8'h0e;
  typedef logic [31:0] aes_col_t;
  typedef logic [127:0] aes_state_t;
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY_LO : 8'h00);
  endfunction
endpackage

// File: rtl/inv_mix_column.sv
// inv_mix_column: combinational InvMixColumns transform of one 32-bit column
module inv_mix_column
  import aes_pkg::*;
(
  input  aes_col_t col_in,
  output aes_col_t col_out
);
  // constants 09/0b/0d/0e only use bits x8,x4,x2,x1 of the xtime chain
  function automatic logic [7:0] mul(input logic [7:0] b, input logic [3:0] c);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return ({8{c[3]}} & x8) ^ ({8{c[2]}} & x4) ^ ({8{c[1]}} & x2) ^ ({8{c[0]}} & b);
  endfunction
  localparam logic [3:0] M9 = INV_MC_09[3:0];
  localparam logic [3:0] MB = INV_MC_0B[3:0];
  localparam logic [3:0] MD = INV_MC_0D[3:0];
  localparam logic [3:0] ME = INV_MC_0E[3:0];
  logic [7:0] a0, a1, a2, a3;
  assign {a0, a1, a2, a3} = col_in;
  assign col_out = {
    mul(a0, ME) ^ mul(a1, MB) ^ mul(a2, MD) ^ mul(a3, M9),
    mul(a0, M9) ^ mul(a1, ME) ^ mul(a2, MB) ^ mul(a3, MD),
    mul(a0, MD) ^ mul(a1, M9) ^ mul(a2, ME) ^ mul(a3, MB),
    mul(a0, MB) ^ mul(a1, MD) ^ mul(a2, M9) ^ mul(a3, ME)
  };
endmodule

// File: rtl/aes_inv_mix_columns_seq.sv
// aes_inv_mix_columns_seq: iterative InvMixColumns engine with valid/ready in and out
module aes_inv_mix_columns_seq
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  aes_state_t state_in,
  output logic       out_valid,
  input  logic       out_ready,
  output aes_state_t state_out
);
  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
    $error("COLS_PER_CYCLE must be 1, 2 or 4");
  end
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [1:0] STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST = 2'(4 - COLS_PER_CYCLE);
  logic [1:0] fsm, col_cnt;
  // column c of the state lives at w[~c], so column 0 is the MSB word
  aes_col_t [3:0] w, next_w;
  logic [1:0] idx [COLS_PER_CYCLE];
  aes_col_t col_in [COLS_PER_CYCLE];
  aes_col_t col_out [COLS_PER_CYCLE];
  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
    assign idx[g] = col_cnt + 2'(g);
    assign col_in[g] = w[~idx[g]];
    inv_mix_column u_col (.col_in(col_in[g]), .col_out(col_out[g]));
  end
  always_comb begin
    next_w = w;
    for (int i = 0; i < COLS_PER_CYCLE; i++) next_w[~idx[i]] = col_out[i];
  end
  assign in_ready = fsm == IDLE;
  assign out_valid = fsm == DONE;
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm <= IDLE;
      col_cnt <= 2'd0;
      state_out <= '0;
      w <= '0;
    end else begin
      if (fsm == IDLE && in_valid) begin
        w <= state_in;
        col_cnt <= 2'd0;
        fsm <= BUSY;
      end
      if (fsm == BUSY) begin
        w <= next_w;
        col_cnt <= col_cnt + STEP;
        if (col_cnt == LAST) begin
          fsm <= DONE;
          state_out <= next_w;
        end
      end
      if (fsm == DONE && out_ready) fsm <= IDLE;
    end
  end
endmodule

// File: tb/tb_aes_inv_mix_columns_seq.sv
// tb_aes_inv_mix_columns_seq: randomized check of all three widths against a GF(2^8) matrix model
module tb_aes_inv_mix_columns_seq;
  logic clk = 0;
  logic rst;
  logic [127:0] state_in;
  logic iv [3];
  logic orr [3];
  logic ir [3];
  logic ov [3];
  logic [127:0] so [3];
  int n_chk = 0;
  int n_pass = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    aes_inv_mix_columns_seq #(.COLS_PER_CYCLE(1 << g)) dut (
      .clk(clk), .rst(rst), .in_valid(iv[g]), .in_ready(ir[g]), .state_in(state_in),
      .out_valid(ov[g]), .out_ready(orr[g]), .state_out(so[g])
    );
  end
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b >>= 1;
    end
    return p;
  endfunction
  // row r of a circulant matrix: b_r = sum_j coef[(j-r) mod 4] * a_j
  function automatic logic [127:0] mat(input logic [127:0] s, input logic [31:0] row0);
    logic [127:0] r = 0;
    logic [7:0] coef [4];
    for (int j = 0; j < 4; j++) coef[j] = row0[31-8*j -: 8];
    for (int c = 0; c < 4; c++)
      for (int i = 0; i < 4; i++) begin
        logic [7:0] acc = 0;
        for (int j = 0; j < 4; j++) acc ^= gmul(s[127-32*c-8*j -: 8], coef[(j - i + 4) % 4]);
        r[127-32*c-8*i -: 8] = acc;
      end
    return r;
  endfunction
  function automatic logic [127:0] inv_ref(input logic [127:0] s);
    return mat(s, 32'h0e0b0d09);
  endfunction
  function automatic logic [127:0] fwd_ref(input logic [127:0] s);
    return mat(s, 32'h02030101);
  endfunction
  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  task automatic xfer(input int k, input logic [127:0] s, output logic [127:0] r);
    int lat = 0;
    bit busy_ok = 1;
    chk("ready_before", ir[k], 1);
    state_in = s;
    iv[k] = 1;
    @(posedge clk); #1;
    iv[k] = 0;
    while (!ov[k] && lat < 20) begin
      if (ir[k]) busy_ok = 0;
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, 4 >> k);
    chk("busy_not_ready", busy_ok, 1);
    r = so[k];
    orr[k] = 1;
    @(posedge clk); #1;
    orr[k] = 0;
    chk("ready_after", {ir[k], ov[k]}, 2'b10);
  endtask
  initial begin
    logic [127:0] r, s, hold;
    logic [127:0] v [3];
    int acc_t [3];
    int n_acc, n_out, lat;
    bit acc;
    rst = 1;
    state_in = 0;
    for (int k = 0; k < 3; k++) begin iv[k] = 0; orr[k] = 0; end
    repeat (2) @(posedge clk);
    #1 rst = 0;
    for (int k = 0; k < 3; k++) chk("reset", {ir[k], ov[k], so[k]}, {2'b10, 128'h0});
    for (int k = 0; k < 3; k++) begin
      xfer(k, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, r);
      chk("vector1", r, 128'hdb135345_f20a225c_01010101_c6c6c6c6);
      xfer(k, {4{32'hd5d5d7d6}}, r);
      chk("vector2", r, {4{32'hd4d4d4d5}});
      s = rnd128();
      xfer(k, s, r);
      chk("random_inv", r, inv_ref(s));
    end
    for (int i = 0; i < 1000; i++) begin
      s = rnd128();
      xfer(i % 3, fwd_ref(s), r);
      chk("round_trip", r, s);
    end
    // backpressure on COLS=1
    s = rnd128();
    state_in = s;
    iv[0] = 1;
    @(posedge clk); #1;
    iv[0] = 0;
    lat = 0;
    while (!ov[0] && lat < 20) begin @(posedge clk); #1; lat++; end
    chk("bp_latency", lat, 4);
    hold = so[0];
    chk("bp_value", hold, inv_ref(s));
    for (int i = 0; i < 10; i++) begin
      iv[0] = i[0];
      state_in = rnd128();
      @(posedge clk); #1;
      chk("bp_hold", {ov[0], ir[0], so[0]}, {2'b10, hold});
    end
    iv[0] = 0;
    orr[0] = 1;
    @(posedge clk); #1;
    orr[0] = 0;
    chk("bp_release", {ir[0], ov[0]}, 2'b10);
    // reset after two columns
    state_in = rnd128();
    iv[0] = 1;
    @(posedge clk); #1;
    iv[0] = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("mid_reset", {ov[0], ir[0], so[0]}, {2'b01, 128'h0});
    xfer(0, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, r);
    chk("after_reset", r, 128'hdb135345_f20a225c_01010101_c6c6c6c6);
    // back-to-back streaming
    for (int i = 0; i < 3; i++) v[i] = rnd128();
    n_acc = 0;
    n_out = 0;
    state_in = v[0];
    iv[0] = 1;
    orr[0] = 1;
    for (int cyc = 0; cyc < 60 && n_out < 3; cyc++) begin
      acc = ir[0] && iv[0];
      if (ov[0]) begin
        chk("b2b_out", so[0], inv_ref(v[n_out]));
        n_out++;
      end
      @(posedge clk); #1;
      if (acc) begin
        acc_t[n_acc] = cyc;
        n_acc++;
        if (n_acc < 3) state_in = v[n_acc];
        else iv[0] = 0;
      end
    end
    iv[0] = 0;
    orr[0] = 0;
    chk("b2b_count", {n_acc[7:0], n_out[7:0]}, {8'd3, 8'd3});
    if (n_acc == 3) begin
      chk("b2b_gap1", acc_t[1] - acc_t[0], 6);
      chk("b2b_gap2", acc_t[2] - acc_t[1], 6);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
